// File: rtl/video_pkg.sv
// video_pkg
// Shared definitions for the renderer and its debug sinks: default raster
// size, CRC-32 constants, error-bit indices and the signature receiver
// state encoding.
// Ports: none (package).
package video_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    localparam int ERR_ORDER   = 0;
    localparam int ERR_RANGE   = 1;
    localparam int ERR_OVERRUN = 2;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } rx_state_t;

endpackage

// File: rtl/crc32_d24.sv
// crc32_d24
// One pixel's worth (24 bits) of non-reflected CRC-32, MSB of data first.
// Purely combinational.
// Ports:
//   crc_in  [31:0]  running CRC before this pixel
//   data    [23:0]  {r, g, b}, shifted in from bit 23 down to bit 0
//   crc_out [31:0]  running CRC after this pixel
module crc32_d24
    import video_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [23:0] data,
    output logic [31:0] crc_out
);

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/frame_sig_rx.sv
// frame_sig_rx
// Reduces each complete, correctly ordered active frame of a pixel stream
// to a CRC-32 signature and hands it out over a valid/ready handshake.
// Also flags raster-order, out-of-area and signature-overrun errors.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SYNC   | waiting for an accepted pixel at (0,0); other pixels ignored
// ACTIVE | accumulating a frame; expecting pixel (exp_x, exp_y)
//
// Ports:
//   clk_in, rst_n_in          pixel clock, async active-low reset
//   sx_in, sy_in, de_in       pixel position and data enable
//   r_in, g_in, b_in          pixel colour
//   sig_ready_in              consumer takes the current signature
//   err_clr_in                clears sticky error bits
//   sig_out, sig_valid_out    signature and its valid flag
//   frame_cnt_out             signatures published (wraps)
//   err_out                   sticky {overrun, range, order}
module frame_sig_rx
    import video_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [9:0]  sx_in,
    input  logic [9:0]  sy_in,
    input  logic        de_in,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    input  logic        sig_ready_in,
    input  logic        err_clr_in,
    output logic [31:0] sig_out,
    output logic        sig_valid_out,
    output logic [15:0] frame_cnt_out,
    output logic [2:0]  err_out
);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    // Stage 1: input register
    logic        de_q;
    logic [9:0]  sx_q, sy_q;
    logic [23:0] rgb_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            de_q  <= 1'b0;
            sx_q  <= '0;
            sy_q  <= '0;
            rgb_q <= '0;
        end else begin
            de_q  <= de_in;
            sx_q  <= sx_in;
            sy_q  <= sy_in;
            rgb_q <= {r_in, g_in, b_in};
        end
    end

    // Stage 2: ordering check and CRC accumulation
    rx_state_t   state;
    logic [31:0] crc, crc_seed, crc_next;
    logic [9:0]  exp_x, exp_y, nxt_x, nxt_y;
    logic        in_range, acc, rng_err, is_origin, is_exp, is_last;
    logic        pub_pend, ord_pend, rng_pend;

    assign in_range  = ({1'b0, sx_q} < 11'(H_RES)) && ({1'b0, sy_q} < 11'(V_RES));
    assign acc       = de_q && in_range;
    assign rng_err   = de_q && !in_range;
    assign is_origin = (sx_q == 10'd0) && (sy_q == 10'd0);
    assign is_exp    = (sx_q == exp_x) && (sy_q == exp_y);
    assign is_last   = (sx_q == X_LAST) && (sy_q == Y_LAST);

    // Next expected position is always derived from the accepted pixel;
    // every path that updates exp_* has just accepted an in-order pixel.
    assign nxt_x = (sx_q == X_LAST) ? 10'd0 : sx_q + 10'd1;
    assign nxt_y = (sx_q == X_LAST) ? sy_q + 10'd1 : sy_q;

    // A frame (re)starts from CRC_INIT whenever the pixel is not a continuation.
    assign crc_seed = (state == ACTIVE && is_exp) ? crc : CRC_INIT;

    crc32_d24 u_crc (
        .crc_in  (crc_seed),
        .data    (rgb_q),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= SYNC;
            crc      <= CRC_INIT;
            exp_x    <= '0;
            exp_y    <= '0;
            pub_pend <= 1'b0;
            ord_pend <= 1'b0;
            rng_pend <= 1'b0;
        end else begin
            pub_pend <= 1'b0;
            ord_pend <= 1'b0;
            rng_pend <= rng_err;
            if (acc) begin
                case (state)
                    SYNC: begin
                        if (is_origin) begin
                            crc <= crc_next;
                            if (is_last) begin
                                pub_pend <= 1'b1;   // 1x1 raster
                            end else begin
                                state <= ACTIVE;
                                exp_x <= nxt_x;
                                exp_y <= nxt_y;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (is_exp) begin
                            crc <= crc_next;
                            if (is_last) begin
                                pub_pend <= 1'b1;
                                state    <= SYNC;
                            end else begin
                                exp_x <= nxt_x;
                                exp_y <= nxt_y;
                            end
                        end else begin
                            ord_pend <= 1'b1;
                            if (is_origin) begin
                                crc   <= crc_next;
                                exp_x <= nxt_x;
                                exp_y <= nxt_y;
                            end else begin
                                state <= SYNC;
                            end
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

    // Stage 3: signature handshake and sticky errors.
    // crc still holds the finished frame here even if a new (0,0) is
    // being folded in on this same edge.
    logic       overrun;
    logic [2:0] err_ev;

    assign overrun = pub_pend && sig_valid_out && !sig_ready_in;

    always_comb begin
        err_ev              = '0;
        err_ev[ERR_ORDER]   = ord_pend;
        err_ev[ERR_RANGE]   = rng_pend;
        err_ev[ERR_OVERRUN] = overrun;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sig_out       <= '0;
            sig_valid_out <= 1'b0;
            frame_cnt_out <= '0;
            err_out       <= '0;
        end else begin
            if (pub_pend) begin
                sig_out       <= crc;
                sig_valid_out <= 1'b1;
                frame_cnt_out <= frame_cnt_out + 16'd1;
            end else if (sig_ready_in) begin
                sig_valid_out <= 1'b0;
            end
            err_out <= (err_clr_in ? 3'b000 : err_out) | err_ev;
        end
    end

endmodule

// File: tb/tb_frame_sig_rx.sv
module tb_frame_sig_rx;

    localparam int HR = 4;
    localparam int VR = 2;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [9:0]  sx_in, sy_in;
    logic        de_in;
    logic [7:0]  r_in, g_in, b_in;
    logic        sig_ready_in;
    logic        err_clr_in;
    logic [31:0] sig_out;
    logic        sig_valid_out;
    logic [15:0] frame_cnt_out;
    logic [2:0]  err_out;

    always #5 clk_in = ~clk_in;

    frame_sig_rx #(.H_RES(HR), .V_RES(VR)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .sx_in         (sx_in),
        .sy_in         (sy_in),
        .de_in         (de_in),
        .r_in          (r_in),
        .g_in          (g_in),
        .b_in          (b_in),
        .sig_ready_in  (sig_ready_in),
        .err_clr_in    (err_clr_in),
        .sig_out       (sig_out),
        .sig_valid_out (sig_valid_out),
        .frame_cnt_out (frame_cnt_out),
        .err_out       (err_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] sig;
        logic [15:0] cnt;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] exp_cnt;

    // Byte-wise reference CRC-32 (poly 04C11DB7, MSB first, no reflection)
    function automatic logic [31:0] model_step(input logic [31:0] c, input logic [23:0] rgb);
        logic [31:0] r;
        r = c;
        for (int b = 2; b >= 0; b--) begin
            r = r ^ {rgb[b*8 +: 8], 24'h0};
            for (int k = 0; k < 8; k++)
                r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [23:0] pix_col(input int seed, input int x, input int y);
        if (seed == 0) return 24'h0;
        return {8'(seed * 17 + x * 29), 8'(y * 53 + seed), 8'(x * y + seed * 7)};
    endfunction

    task automatic drive(input int x, input int y, input logic de, input logic [23:0] rgb);
        @(negedge clk_in);
        sx_in = 10'(x);
        sy_in = 10'(y);
        de_in = de;
        {r_in, g_in, b_in} = rgb;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            de_in = 1'b0;
        end
    endtask

    // Returns right after the last pixel is driven (before it is sampled).
    // skip_x>=0 drops one pixel; stop_after>=0 truncates; neither publishes.
    task automatic send_frame(input int seed, input int gap, input int skip_x, input int skip_y,
                              input int stop_after, input bit inject_rng);
        logic [31:0] c;
        int          cnt;
        sb_t         e;
        c   = 32'hFFFF_FFFF;
        cnt = 0;
        for (int y = 0; y < VR; y++) begin
            for (int x = 0; x < HR; x++) begin
                if (x == skip_x && y == skip_y) continue;
                if (stop_after >= 0 && cnt == stop_after) return;
                drive(x, y, 1'b1, pix_col(seed, x, y));
                c = model_step(c, pix_col(seed, x, y));
                cnt++;
                if (inject_rng && x == 1 && y == 0) drive(HR, 0, 1'b1, 24'hABCDEF);
                if (!(x == HR - 1 && y == VR - 1)) idle(gap);
            end
        end
        if (skip_x < 0 && stop_after < 0) begin
            exp_cnt = exp_cnt + 16'd1;
            e.sig   = c;
            e.cnt   = exp_cnt;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
            @(negedge clk_in);
            #1;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic consume();
        @(negedge clk_in);
        sig_ready_in = 1'b1;
        @(negedge clk_in);
        sig_ready_in = 1'b0;
        chk("valid_after_ready", 32'(sig_valid_out), 32'd0);
    endtask

    task automatic clear_err();
        @(negedge clk_in);
        err_clr_in = 1'b1;
        @(negedge clk_in);
        err_clr_in = 1'b0;
        chk("err_cleared", 32'(err_out), 32'd0);
    endtask

    // Publish monitor: every frame_cnt_out step must match the next scoreboard entry
    logic [15:0] prev_cnt;
    sb_t         mon_e;

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            prev_cnt = 16'd0;
        end else if (frame_cnt_out != prev_cnt) begin
            prev_cnt = frame_cnt_out;
            if (sb_q.size() == 0) begin
                chk("pub_unexpected", 32'd0, 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sig", sig_out, mon_e.sig);
                chk("frame_cnt", 32'(frame_cnt_out), 32'(mon_e.cnt));
                chk("valid_on_pub", 32'(sig_valid_out), 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n_in     = 1'b0;
        sx_in        = '0;
        sy_in        = '0;
        de_in        = 1'b0;
        {r_in, g_in, b_in} = '0;
        sig_ready_in = 1'b0;
        err_clr_in   = 1'b0;
        exp_cnt      = 16'd0;

        repeat (3) @(negedge clk_in);
        chk("rst_sig", sig_out, 32'd0);
        chk("rst_valid", 32'(sig_valid_out), 32'd0);
        chk("rst_cnt", 32'(frame_cnt_out), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);
        rst_n_in = 1'b1;
        idle(2);

        // Smoke frame, black, 3-cycle gaps, with exact publish latency
        send_frame(0, 3, -1, -1, -1, 1'b0);
        idle(1);
        chk("lat_n", 32'(sig_valid_out), 32'd0);
        idle(1);
        chk("lat_n1", 32'(sig_valid_out), 32'd0);
        idle(1);
        chk("lat_n2", 32'(sig_valid_out), 32'd1);
        chk("smoke_cnt", 32'(frame_cnt_out), 32'd1);
        chk("smoke_err", 32'(err_out), 32'd0);
        idle(4);
        chk("valid_hold", 32'(sig_valid_out), 32'd1);
        wait_drain();
        consume();

        // Ordering error: skip (2,0)
        send_frame(2, 0, 2, 0, -1, 1'b0);
        idle(5);
        chk("order_err", 32'(err_out), 32'b001);
        chk("order_cnt", 32'(frame_cnt_out), 32'(exp_cnt));
        chk("order_nopub", 32'(sig_valid_out), 32'd0);
        clear_err();
        send_frame(2, 1, -1, -1, -1, 1'b0);
        idle(4);
        wait_drain();
        consume();

        // Early (0,0) mid-frame restarts accumulation
        send_frame(3, 0, -1, -1, 3, 1'b0);
        send_frame(4, 0, -1, -1, -1, 1'b0);
        idle(4);
        wait_drain();
        chk("restart_err", 32'(err_out), 32'b001);
        clear_err();
        consume();

        // Overrun: two back-to-back frames, nobody reading
        send_frame(5, 0, -1, -1, -1, 1'b0);
        send_frame(6, 0, -1, -1, -1, 1'b0);
        idle(4);
        wait_drain();
        chk("ovr_err", 32'(err_out), 32'b100);
        chk("ovr_valid", 32'(sig_valid_out), 32'd1);
        clear_err();

        // Ready on the publish edge while valid: no overrun
        send_frame(7, 1, -1, -1, -1, 1'b0);
        idle(1);
        @(negedge clk_in);
        sig_ready_in = 1'b1;
        @(negedge clk_in);
        sig_ready_in = 1'b0;
        chk("pub_ready_valid", 32'(sig_valid_out), 32'd1);
        chk("pub_ready_err", 32'(err_out), 32'd0);
        wait_drain();
        consume();

        // Out-of-area pixel inside a frame: flagged, CRC unaffected
        send_frame(8, 0, -1, -1, -1, 1'b1);
        idle(4);
        wait_drain();
        chk("range_err", 32'(err_out), 32'b010);
        clear_err();

        // Async reset mid-frame with a signature still pending
        send_frame(9, 0, -1, -1, -1, 1'b0);
        idle(3);
        wait_drain();
        send_frame(10, 0, -1, -1, 5, 1'b0);
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_sig", sig_out, 32'd0);
        chk("arst_valid", 32'(sig_valid_out), 32'd0);
        chk("arst_cnt", 32'(frame_cnt_out), 32'd0);
        chk("arst_err", 32'(err_out), 32'd0);
        exp_cnt = 16'd0;
        idle(2);
        rst_n_in = 1'b1;
        idle(2);
        send_frame(11, 2, -1, -1, -1, 1'b0);
        idle(4);
        wait_drain();
        chk("post_rst_cnt", 32'(frame_cnt_out), 32'd1);

        chk("sb_left", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
